// File: rtl/pe_power_domain_ctrl.sv
// Power-domain sequencer for one gated PE group: walks the domain through
// clock gate, isolation, retention, power switch and domain reset in order.
module pe_power_domain_ctrl #(
    parameter int SETTLE_CYCLES   = 4,
    parameter int RST_HOLD_CYCLES = 2,
    parameter int TIMEOUT_CYCLES  = 16,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwr_req,
    input  logic             pwr_good,
    output logic             pwr_ack,
    output logic             busy,
    output logic             clk_en,
    output logic             iso_en,
    output logic             ret_save,
    output logic             ret_restore,
    output logic             pwr_sw_en,
    output logic             dom_rst,
    output logic             err,
    output logic [3:0]       state
);

    typedef enum logic [3:0] {
        OFF      = 4'd0,
        SW_ON    = 4'd1,
        SETTLE   = 4'd2,
        RST_HOLD = 4'd3,
        RESTORE  = 4'd4,
        DEISO    = 4'd5,
        UNGATE   = 4'd6,
        ON       = 4'd7,
        GATE_CLK = 4'd8,
        ISOLATE  = 4'd9,
        SAVE     = 4'd10,
        SW_OFF   = 4'd11,
        ERR      = 4'd12
    } state_t;

    // Counters are loaded with N-1 so that a timed state lasts exactly N cycles.
    localparam logic [CNT_W-1:0] SETTLE_LOAD   = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_HOLD_LOAD = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD  = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;
    logic             cnt_zero;

    logic busy_d, clk_en_d, iso_en_d, ret_save_d, ret_restore_d;
    logic pwr_sw_en_d, dom_rst_d, err_d, pwr_ack_d;

    assign cnt_zero = (cnt_q == '0);
    assign state    = state_q;

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        case (state_q)
            OFF: begin
                if (pwr_req) begin
                    state_nxt = SW_ON;
                    cnt_nxt   = TIMEOUT_LOAD;
                end
            end
            SW_ON: begin
                if (pwr_good) begin
                    state_nxt = SETTLE;
                    cnt_nxt   = SETTLE_LOAD;
                end else if (cnt_zero) begin
                    state_nxt = ERR;
                end else begin
                    cnt_nxt = cnt_q - 1'b1;
                end
            end
            SETTLE: begin
                if (!pwr_good) begin
                    state_nxt = ERR;
                end else if (cnt_zero) begin
                    state_nxt = RST_HOLD;
                    cnt_nxt   = RST_HOLD_LOAD;
                end else begin
                    cnt_nxt = cnt_q - 1'b1;
                end
            end
            RST_HOLD: begin
                if (!pwr_good) begin
                    state_nxt = ERR;
                end else if (cnt_zero) begin
                    state_nxt = RESTORE;
                end else begin
                    cnt_nxt = cnt_q - 1'b1;
                end
            end
            RESTORE:  state_nxt = DEISO;
            DEISO:    state_nxt = UNGATE;
            UNGATE:   state_nxt = ON;
            // A supply fault outranks a power-down request.
            ON: begin
                if (!pwr_good) begin
                    state_nxt = ERR;
                end else if (!pwr_req) begin
                    state_nxt = GATE_CLK;
                end
            end
            GATE_CLK: state_nxt = ISOLATE;
            ISOLATE:  state_nxt = SAVE;
            SAVE: begin
                state_nxt = SW_OFF;
                cnt_nxt   = SETTLE_LOAD;
            end
            SW_OFF: begin
                if (cnt_zero) begin
                    state_nxt = OFF;
                end else begin
                    cnt_nxt = cnt_q - 1'b1;
                end
            end
            ERR: begin
                if (!pwr_req) begin
                    state_nxt = OFF;
                end
            end
            default:  state_nxt = OFF;
        endcase
    end

    // Outputs are decoded from the next state so the registers line up with state_q.
    always_comb begin
        busy_d        = 1'b1;
        clk_en_d      = 1'b0;
        iso_en_d      = 1'b1;
        ret_save_d    = 1'b0;
        ret_restore_d = 1'b0;
        pwr_sw_en_d   = 1'b1;
        dom_rst_d     = 1'b0;
        err_d         = 1'b0;
        pwr_ack_d     = pwr_ack;
        case (state_nxt)
            OFF: begin
                busy_d      = 1'b0;
                pwr_sw_en_d = 1'b0;
                dom_rst_d   = 1'b1;
                pwr_ack_d   = 1'b0;
            end
            SW_ON, SETTLE, RST_HOLD: dom_rst_d = 1'b1;
            RESTORE:  ret_restore_d = 1'b1;
            DEISO, UNGATE, GATE_CLK: iso_en_d = 1'b0;
            ON: begin
                busy_d    = 1'b0;
                clk_en_d  = 1'b1;
                iso_en_d  = 1'b0;
                pwr_ack_d = 1'b1;
            end
            ISOLATE:  iso_en_d = 1'b1;
            SAVE:     ret_save_d = 1'b1;
            SW_OFF: begin
                pwr_sw_en_d = 1'b0;
                dom_rst_d   = 1'b1;
            end
            ERR: begin
                busy_d      = 1'b0;
                pwr_sw_en_d = 1'b0;
                dom_rst_d   = 1'b1;
                err_d       = 1'b1;
            end
            default: begin
                busy_d      = 1'b0;
                pwr_sw_en_d = 1'b0;
                dom_rst_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= OFF;
            cnt_q       <= '0;
            pwr_ack     <= 1'b0;
            busy        <= 1'b0;
            clk_en      <= 1'b0;
            iso_en      <= 1'b1;
            ret_save    <= 1'b0;
            ret_restore <= 1'b0;
            pwr_sw_en   <= 1'b0;
            dom_rst     <= 1'b1;
            err         <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            cnt_q       <= cnt_nxt;
            pwr_ack     <= pwr_ack_d;
            busy        <= busy_d;
            clk_en      <= clk_en_d;
            iso_en      <= iso_en_d;
            ret_save    <= ret_save_d;
            ret_restore <= ret_restore_d;
            pwr_sw_en   <= pwr_sw_en_d;
            dom_rst     <= dom_rst_d;
            err         <= err_d;
        end
    end

endmodule

// File: tb/tb_pe_power_domain_ctrl.sv
// Bench for pe_power_domain_ctrl: directed sequences with literal expectations,
// then random request/supply/reset traffic against a state-and-dwell-time model.
module tb_pe_power_domain_ctrl;

    localparam int SETTLE   = 4;
    localparam int RST_HOLD = 2;
    localparam int TIMEOUT  = 16;

    logic clk = 1'b0;
    logic rst, pwr_req, pwr_good;
    logic pwr_ack, busy, clk_en, iso_en, ret_save, ret_restore;
    logic pwr_sw_en, dom_rst, err;
    logic [3:0] state;

    int check_count = 0;
    int pass_count  = 0;

    int   m_state = 0;
    int   m_time  = 0;
    logic m_ack   = 1'b0;
    logic m_live  = 1'b0;

    pe_power_domain_ctrl #(
        .SETTLE_CYCLES(SETTLE), .RST_HOLD_CYCLES(RST_HOLD),
        .TIMEOUT_CYCLES(TIMEOUT), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .pwr_req(pwr_req), .pwr_good(pwr_good),
        .pwr_ack(pwr_ack), .busy(busy), .clk_en(clk_en), .iso_en(iso_en),
        .ret_save(ret_save), .ret_restore(ret_restore), .pwr_sw_en(pwr_sw_en),
        .dom_rst(dom_rst), .err(err), .state(state)
    );

    always #5 clk = ~clk;

    // Expected outputs from state membership; field order matches dut_vec below.
    function automatic logic [12:0] exp_out(int s, logic a);
        logic e_busy, e_clk, e_iso, e_save, e_rest, e_sw, e_rst, e_err;
        e_busy = !(s inside {0, 7, 12});
        e_clk  = (s == 7);
        e_iso  = (s inside {0, 1, 2, 3, 4, 9, 10, 11, 12});
        e_save = (s == 10);
        e_rest = (s == 4);
        e_sw   = (s >= 1 && s <= 10);
        e_rst  = (s inside {0, 1, 2, 3, 11, 12});
        e_err  = (s == 12);
        return {4'(s), a, e_busy, e_clk, e_iso, e_save, e_rest, e_sw, e_rst, e_err};
    endfunction

    // Model: state number plus how many cycles it has already dwelt there.
    always @(posedge clk) begin
        int n;
        int nx;
        n  = m_time + 1;
        nx = m_state;
        if (rst) begin
            nx = 0;
        end else begin
            case (m_state)
                0:  if (pwr_req) nx = 1;
                1:  if (pwr_good) nx = 2; else if (n == TIMEOUT) nx = 12;
                2:  if (!pwr_good) nx = 12; else if (n == SETTLE) nx = 3;
                3:  if (!pwr_good) nx = 12; else if (n == RST_HOLD) nx = 4;
                4, 5, 6, 8, 9, 10: nx = m_state + 1;
                7:  if (!pwr_good) nx = 12; else if (!pwr_req) nx = 8;
                11: if (n == SETTLE) nx = 0;
                12: if (!pwr_req) nx = 0;
                default: nx = 0;
            endcase
        end
        m_time  = (rst || nx != m_state) ? 0 : n;
        m_state = nx;
        if (nx == 7) m_ack = 1'b1;
        if (nx == 0) m_ack = 1'b0;
        m_live = 1'b1;
    end

    wire [12:0] dut_vec = {state, pwr_ack, busy, clk_en, iso_en, ret_save,
                           ret_restore, pwr_sw_en, dom_rst, err};

    always @(negedge clk) begin
        if (m_live) begin
            logic [12:0] e;
            e = exp_out(m_state, m_ack);
            check_count++;
            if (dut_vec === e) pass_count++;
            else $display("[TB] FAIL model_cmp t=%0t got=%h expected=%h", $time, dut_vec, e);
        end
    end

    task automatic applyStimulus(input logic req, input logic good, input logic r);
        pwr_req  = req;
        pwr_good = good;
        rst      = r;
    endtask

    task automatic waitEdges(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        check_count++;
        if (actual == expected) pass_count++;
        else $display("[TB] FAIL %s got=%0d expected=%0d", name, actual, expected);
    endtask

    initial begin
        applyStimulus(1'b1, 1'b1, 1'b1);
        waitEdges(2);
        checkOutput("rst_state", state, 0);
        checkOutput("rst_iso", iso_en, 1);
        checkOutput("rst_domrst", dom_rst, 1);
        checkOutput("rst_clken", clk_en, 0);
        checkOutput("rst_sw", pwr_sw_en, 0);
        checkOutput("rst_ack", pwr_ack, 0);
        checkOutput("rst_err", err, 0);

        $display("[TB] power-up");
        applyStimulus(1'b1, 1'b1, 1'b0);
        waitEdges(1);
        checkOutput("up_sw_e0", pwr_sw_en, 1);
        checkOutput("up_busy_e0", busy, 1);
        waitEdges(6);
        checkOutput("up_domrst_e6", dom_rst, 1);
        waitEdges(1);
        checkOutput("up_domrst_e7", dom_rst, 0);
        checkOutput("up_restore_e7", ret_restore, 1);
        waitEdges(1);
        checkOutput("up_restore_e8", ret_restore, 0);
        checkOutput("up_iso_e8", iso_en, 0);
        waitEdges(1);
        checkOutput("up_ack_e9", pwr_ack, 0);
        waitEdges(1);
        checkOutput("up_clken_e10", clk_en, 1);
        checkOutput("up_ack_e10", pwr_ack, 1);
        checkOutput("up_busy_e10", busy, 0);

        $display("[TB] power-down");
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitEdges(1);
        checkOutput("dn_clken_e0", clk_en, 0);
        waitEdges(1);
        checkOutput("dn_iso_e1", iso_en, 1);
        waitEdges(1);
        checkOutput("dn_save_e2", ret_save, 1);
        waitEdges(1);
        checkOutput("dn_save_e3", ret_save, 0);
        checkOutput("dn_sw_e3", pwr_sw_en, 0);
        waitEdges(3);
        checkOutput("dn_ack_e6", pwr_ack, 1);
        waitEdges(1);
        checkOutput("dn_state_e7", state, 0);
        checkOutput("dn_ack_e7", pwr_ack, 0);

        $display("[TB] timeout");
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitEdges(16);
        checkOutput("to_state_e15", state, 1);
        waitEdges(1);
        checkOutput("to_state_e16", state, 12);
        checkOutput("to_err", err, 1);
        checkOutput("to_sw", pwr_sw_en, 0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitEdges(1);
        checkOutput("to_clear_state", state, 0);
        checkOutput("to_clear_err", err, 0);

        $display("[TB] request flip during settle");
        applyStimulus(1'b1, 1'b1, 1'b0);
        waitEdges(2);
        checkOutput("flip_settle", state, 2);
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitEdges(9);
        checkOutput("flip_on", state, 7);
        checkOutput("flip_ack", pwr_ack, 1);
        waitEdges(1);
        checkOutput("flip_gate", state, 8);
        waitEdges(10);
        checkOutput("flip_off", state, 0);

        $display("[TB] supply fault in ON");
        applyStimulus(1'b1, 1'b1, 1'b0);
        waitEdges(11);
        checkOutput("flt_on", state, 7);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitEdges(1);
        checkOutput("flt_state", state, 12);
        checkOutput("flt_clken", clk_en, 0);
        checkOutput("flt_iso", iso_en, 1);
        checkOutput("flt_ack_hold", pwr_ack, 1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitEdges(1);
        checkOutput("flt_exit", state, 0);
        checkOutput("flt_exit_ack", pwr_ack, 0);

        $display("[TB] reset in RST_HOLD");
        applyStimulus(1'b1, 1'b1, 1'b0);
        waitEdges(6);
        checkOutput("rh_state", state, 3);
        applyStimulus(1'b1, 1'b1, 1'b1);
        waitEdges(1);
        checkOutput("rh_rst_state", state, 0);
        checkOutput("rh_rst_domrst", dom_rst, 1);
        checkOutput("rh_rst_iso", iso_en, 1);
        checkOutput("rh_rst_sw", pwr_sw_en, 0);
        checkOutput("rh_rst_busy", busy, 0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitEdges(2);

        $display("[TB] random traffic");
        for (int i = 0; i < 3000; i++) begin
            logic req, good, r;
            req  = ($urandom_range(0, 19) == 0) ? ~pwr_req : pwr_req;
            good = pwr_good ? ($urandom_range(0, 39) != 0) : ($urandom_range(0, 3) == 0);
            r    = ($urandom_range(0, 299) == 0);
            applyStimulus(req, good, r);
            waitEdges(1);
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/pe_power_domain_ctrl.md
Name: pe_power_domain_ctrl

Overview:
- Tile-side responder to the array's clock/reset/power controller. Sits between the controller and one PE power domain.
- Accepts a level power request and sequences the domain through the standard order: clock gate, isolation, retention, power switch and domain reset.
- Acknowledges completion so the requester can treat pwr_ack == pwr_req as "done".
- Instantiated once per gated PE group.

Parameters:
SETTLE_CYCLES, 4, cycles the power switch is allowed to settle after pwr_good rises (power-up) and after the switch opens (power-down); legal 1..255
RST_HOLD_CYCLES, 2, cycles dom_rst stays asserted after settling before restore; legal 1..255
TIMEOUT_CYCLES, 16, maximum cycles in SW_ON waiting for pwr_good; legal 1..255
CNT_W, 8, width of the shared down-counter

Ports:
clk  input  1  single clock
rst  input  1  synchronous, active-high reset
pwr_req  input  1  level request: 1 = domain on, 0 = domain off
pwr_good  input  1  power-switch good indication from the domain
pwr_ack  output  1  registered; 1 = domain fully on, 0 = domain fully off; holds its previous value during transitions
busy  output  1  1 in any transitional state
clk_en  output  1  clock-gate enable to the domain
iso_en  output  1  isolation clamp enable
ret_save  output  1  one-cycle retention save strobe
ret_restore  output  1  one-cycle retention restore strobe
pwr_sw_en  output  1  power-switch enable
dom_rst  output  1  active-high reset to the domain
err  output  1  sticky fault flag
state  output  4  current FSM state encoding, for debug

Behaviour:
- All outputs are registered Moore decodes of the state; the state advances on posedge clk only.
- Reset (rst=1 at an edge), from any state:
  - state=OFF; pwr_ack=0, busy=0, clk_en=0, iso_en=1, ret_save=0, ret_restore=0, pwr_sw_en=0, dom_rst=1, err=0.
  - Reset mid-sequence abandons the sequence immediately.
- State encodings: OFF=0, SW_ON=1, SETTLE=2, RST_HOLD=3, RESTORE=4, DEISO=5, UNGATE=6, ON=7, GATE_CLK=8, ISOLATE=9, SAVE=10, SW_OFF=11, ERR=12.
- Output decode per state:
  - OFF: clk_en 0, iso 1, sw 0, dom_rst 1.
  - SW_ON / SETTLE / RST_HOLD: sw 1, iso 1, clk_en 0, dom_rst 1.
  - RESTORE: dom_rst 0, ret_restore 1, iso 1.
  - DEISO: iso 0, clk_en 0.
  - UNGATE: iso 0, clk_en 0.
  - ON: clk_en 1, iso 0, sw 1, dom_rst 0.
  - GATE_CLK: clk_en 0, iso 0.
  - ISOLATE: iso 1.
  - SAVE: iso 1, ret_save 1.
  - SW_OFF: sw 0, iso 1, dom_rst 1.
  - ERR: clk_en 0, iso 1, sw 0, dom_rst 1, err 1.
- Power-up transitions:
  - OFF -> SW_ON when pwr_req=1.
  - SW_ON -> SETTLE when pwr_good=1. Otherwise count; on the TIMEOUT_CYCLES-th cycle without pwr_good -> ERR.
  - SETTLE stays exactly SETTLE_CYCLES cycles -> RST_HOLD.
  - RST_HOLD stays exactly RST_HOLD_CYCLES cycles -> RESTORE.
  - RESTORE -> DEISO -> UNGATE -> ON, one cycle each.
- Power-down transitions:
  - ON -> GATE_CLK when pwr_req=0.
  - GATE_CLK -> ISOLATE -> SAVE, one cycle each.
  - SAVE -> SW_OFF; SW_OFF stays SETTLE_CYCLES cycles -> OFF.
- pwr_ack: set when entering ON; cleared when entering OFF; otherwise unchanged.
- busy: 1 in every state except OFF, ON and ERR.
- pwr_req changes mid-sequence:
  - Ignored until the sequence reaches ON or OFF; no abort, no reversal.
  - Re-evaluated in ON/OFF on the next edge.
- Faults:
  - pwr_good falling to 0 while in ON -> ERR on the next edge; pwr_ack holds 1 until ERR exits.
  - pwr_good dropping during SETTLE / RST_HOLD -> ERR.
  - ERR -> OFF only when pwr_req=0. err clears and pwr_ack is cleared on entering OFF.
- Counter: single CNT_W down-counter, loaded on entry to each timed state; no wrap.

Test Plan:
- Reset: hold rst=1 for 2 cycles with pwr_req=1 -> state=0, iso_en=1, dom_rst=1, clk_en=0, pwr_sw_en=0, pwr_ack=0, err=0.
- Power-up with defaults and pwr_good tied high:
  - pwr_req 0->1 sampled at edge E0 -> pwr_sw_en=1 after E0.
  - dom_rst falls and ret_restore pulses for one cycle after E7.
  - iso_en falls after E8; clk_en rises and pwr_ack=1 after E10.
  - busy=1 between E0 and E10.
- Power-down from ON, pwr_req->0 at E0:
  - clk_en=0 after E0; iso_en=1 after E1.
  - ret_save is a one-cycle pulse after E2.
  - pwr_sw_en=0 after E3; state=OFF and pwr_ack=0 after E7.
- Timeout: pwr_req=1 with pwr_good=0 -> ERR after 16 cycles in SW_ON; err=1, pwr_sw_en=0. Then pwr_req=0 -> OFF with err=0.
- Mid-sequence request flip: pwr_req 1 then 0 during SETTLE -> sequence completes to ON (pwr_ack=1), then the power-down sequence starts on the next edge.
- Faults and reset:
  - Drop pwr_good while in ON -> ERR next edge; clk_en=0, iso_en=1.
  - Assert rst while in RST_HOLD -> OFF next edge with all reset values.
